up_down_counter_n_bit: RTL and testbench
========================================

# up_down_counter_n_bit

Parametrised up/down counter. It generalises the fixed 4-bit up/down counter to:
- configurable width and modulus,
- wrap or saturate mode,
- a clock-enable prescaler,
- synchronous load and clear,
- terminal-count and wrap status.

It sits in the counters/timers library as the base block for timers, PWM period generators and event counters.

## Interface
- WIDTH, 8: counter width in bits; WIDTH ≥ 2.
- MOD_VALUE, 2**WIDTH: modulus; count range is 0 .. MOD_VALUE-1; 2 ≤ MOD_VALUE ≤ 2**WIDTH.
- SATURATE, 0: 0 = wrap at limits; 1 = hold at limits.
- PRESCALE, 1: number of enabled cycles per count step; PRESCALE ≥ 1.
- Clk_In  input  1  clock; all state changes on rising edge.
- Resetb_In  input  1  asynchronous, active-low reset.
- Start_Stopb_In  input  1  1 = count enabled; 0 = hold count and prescaler.
- Up_Downb_In  input  1  1 = count up; 0 = count down.
- Clear_In  input  1  synchronous clear to 0.
- Load_In  input  1  synchronous load of Load_Value_In.
- Load_Value_In  input  WIDTH  load value; values above MOD_VALUE-1 load as MOD_VALUE-1.
- Count_Out  output  WIDTH  current count, registered.
- Max_Out  output  1  combinational; Count_Out == MOD_VALUE-1.
- Min_Out  output  1  combinational; Count_Out == 0.
- Wrap_Out  output  1  registered one-cycle pulse on a wrap event.
- Sat_Out  output  1  registered; SATURATE=1 and a step was blocked at a limit.

## Operation
- Reset (Resetb_In=0) acts immediately, independent of clock:
  - Count_Out=0, prescaler=0, Wrap_Out=0, Sat_Out=0.
  - Hence Min_Out=1 and Max_Out=0.
- Per-edge priority: Clear_In > Load_In > count step.
  - Clear: count=0, prescaler=0, Wrap_Out=0, Sat_Out=0.
  - Load: count = min(Load_Value_In, MOD_VALUE-1), prescaler=0, Wrap_Out=0, Sat_Out=0.
  - Clear and load are honoured regardless of Start_Stopb_In.
- Prescaler: internal counter 0 .. PRESCALE-1.
  - Advances on each edge with Start_Stopb_In=1 and no clear/load.
  - Tick = prescaler at PRESCALE-1 with enable; prescaler then returns to 0.
  - PRESCALE=1 gives a tick every enabled cycle.
  - Start_Stopb_In=0 freezes the prescaler; it does not reset it.
  - A direction change does not reset the prescaler.
- Count step, on tick only:
  - Up, count < MOD_VALUE-1: count+1.
  - Up at MOD_VALUE-1, SATURATE=0: count=0 and Wrap_Out=1 next cycle.
  - Up at MOD_VALUE-1, SATURATE=1: count holds and Sat_Out=1.
  - Down, count > 0: count-1.
  - Down at 0, SATURATE=0: count=MOD_VALUE-1 and Wrap_Out=1.
  - Down at 0, SATURATE=1: count holds and Sat_Out=1.
- Sat_Out is sticky:
  - stays 1 until a tick moves the count off the limit, a clear, a load, or reset;
  - a direction reversal that steps away from the limit clears it on that edge.
- Wrap_Out is 1 only on the cycle following a wrapping tick, otherwise 0; it is never asserted when SATURATE=1.
- All arithmetic is WIDTH bits unsigned. Comparisons are against MOD_VALUE-1, never 2**WIDTH-1, unless they are equal.

## Timing
- Load/clear to Count_Out: 1 cycle (value visible after the edge that samples Load_In/Clear_In).
- Tick to Count_Out: 1 cycle.
- Enable to first step: PRESCALE enabled edges from prescaler=0.
- Wrap_Out and Sat_Out update on the same edge as the count update.
- Max_Out and Min_Out follow Count_Out combinationally, with zero added latency.
- Reset deassertion is synchronised externally; the first counting edge is the first rising edge with Resetb_In=1.
- Reset asserted mid-count clears all state within the same cycle, without waiting for an edge.

## Test plan
Default configuration unless noted: WIDTH=4, MOD_VALUE=10, SATURATE=0, PRESCALE=1.
- Reset, then Start=1, Up=1 for 12 edges -> Count 1..9,0,1,2; Wrap_Out high exactly one cycle, coincident with Count=0; Max_Out high while Count=9.
- Up=0 from Count=0 for 3 edges -> Count 9,8,7; one Wrap_Out pulse, coincident with Count=9.
- Load_In=1 with Load_Value_In=7 and Start=1 -> Count=7 next cycle, then 8. Load 12 -> Count=9. Clear_In and Load_In together -> Count=0.
- SATURATE=1, load 8, Up=1 for 4 edges -> Count 9,9,9,9; Sat_Out=1 from the second edge; Wrap_Out never asserts. Then Up=0 -> Count=8, Sat_Out=0.
- PRESCALE=3, Up=1 -> Count steps every 3rd edge. Drop Start after 2 enabled edges for 5 cycles, then raise it -> next step occurs 1 enabled edge later.
- Resetb_In low between clock edges at Count=5 -> Count_Out=0 and Sat_Out=0 before the next edge; counting resumes from 0 after release.

Source files
------------

// File: rtl/up_down_counter_n_bit.sv
// Parametrised up/down counter with wrap or saturate mode, clock-enable prescaler,
// synchronous clear/load and terminal-count / wrap / saturation status.
module up_down_counter_n_bit #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MOD_VALUE = 2 ** WIDTH,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic             Clk_In,
    input  logic             Resetb_In,
    input  logic             Start_Stopb_In,
    input  logic             Up_Downb_In,
    input  logic             Clear_In,
    input  logic             Load_In,
    input  logic [WIDTH-1:0] Load_Value_In,
    output logic [WIDTH-1:0] Count_Out,
    output logic             Max_Out,
    output logic             Min_Out,
    output logic             Wrap_Out,
    output logic             Sat_Out
);

    // A one-bit prescaler is kept even for PRESCALE=1; it then never leaves zero.
    localparam int unsigned     PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD_VALUE - 1);
    localparam logic [PsW-1:0]   PsLast = PsW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PsW-1:0]   ps_q, ps_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             tick;

    always_comb begin
        count_d = count_q;
        ps_d    = ps_q;
        wrap_d  = 1'b0;
        sat_d   = sat_q;
        tick    = 1'b0;

        if (Clear_In) begin
            count_d = '0;
            ps_d    = '0;
            sat_d   = 1'b0;
        end else if (Load_In) begin
            count_d = (Load_Value_In > MaxVal) ? MaxVal : Load_Value_In;
            ps_d    = '0;
            sat_d   = 1'b0;
        end else if (Start_Stopb_In) begin
            if (ps_q == PsLast) begin
                ps_d = '0;
                tick = 1'b1;
            end else begin
                ps_d = ps_q + 1'b1;
            end

            // Sat stays sticky only while ticks keep getting blocked at a limit.
            if (tick) begin
                sat_d = 1'b0;
                if (Up_Downb_In) begin
                    if (count_q != MaxVal) begin
                        count_d = count_q + 1'b1;
                    end else if (SATURATE != 0) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else if (SATURATE != 0) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = MaxVal;
                        wrap_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk_In or negedge Resetb_In) begin
        if (!Resetb_In) begin
            count_q <= '0;
            ps_q    <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ps_q    <= ps_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign Count_Out = count_q;
    assign Max_Out   = (count_q == MaxVal);
    assign Min_Out   = (count_q == '0);
    assign Wrap_Out  = wrap_q;
    assign Sat_Out   = sat_q;

endmodule

// File: tb/tb_up_down_counter_n_bit.sv
// Bench for up_down_counter_n_bit: directed vector tables plus randomized stimulus
// against an arithmetic reference model, across four parameter configurations.
module tb_up_down_counter_n_bit;

    localparam int NCfg = 4;
    // Config 0: default (mod 10, wrap, ps 1); 1: saturate; 2: prescale 3; 3: full mod 16, ps 2.
    localparam int CfgMod [NCfg] = '{10, 10, 10, 16};
    localparam int CfgSat [NCfg] = '{0, 1, 0, 0};
    localparam int CfgPs  [NCfg] = '{1, 1, 3, 2};

    logic       clk = 1'b0;
    logic       rstb;
    logic       start, up, clr, ld;
    logic [3:0] ldv;

    logic [3:0] cnt_w [NCfg];
    logic       max_w [NCfg];
    logic       min_w [NCfg];
    logic       wrap_w[NCfg];
    logic       sat_w [NCfg];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_cnt[NCfg];
    int m_ps [NCfg];
    bit m_w  [NCfg];
    bit m_s  [NCfg];

    always #5 clk = ~clk;

    up_down_counter_n_bit #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(0), .PRESCALE(1)) u_c0 (
        .Clk_In(clk), .Resetb_In(rstb), .Start_Stopb_In(start), .Up_Downb_In(up),
        .Clear_In(clr), .Load_In(ld), .Load_Value_In(ldv), .Count_Out(cnt_w[0]),
        .Max_Out(max_w[0]), .Min_Out(min_w[0]), .Wrap_Out(wrap_w[0]), .Sat_Out(sat_w[0]));

    up_down_counter_n_bit #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(1), .PRESCALE(1)) u_c1 (
        .Clk_In(clk), .Resetb_In(rstb), .Start_Stopb_In(start), .Up_Downb_In(up),
        .Clear_In(clr), .Load_In(ld), .Load_Value_In(ldv), .Count_Out(cnt_w[1]),
        .Max_Out(max_w[1]), .Min_Out(min_w[1]), .Wrap_Out(wrap_w[1]), .Sat_Out(sat_w[1]));

    up_down_counter_n_bit #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(0), .PRESCALE(3)) u_c2 (
        .Clk_In(clk), .Resetb_In(rstb), .Start_Stopb_In(start), .Up_Downb_In(up),
        .Clear_In(clr), .Load_In(ld), .Load_Value_In(ldv), .Count_Out(cnt_w[2]),
        .Max_Out(max_w[2]), .Min_Out(min_w[2]), .Wrap_Out(wrap_w[2]), .Sat_Out(sat_w[2]));

    up_down_counter_n_bit #(.WIDTH(4), .MOD_VALUE(16), .SATURATE(0), .PRESCALE(2)) u_c3 (
        .Clk_In(clk), .Resetb_In(rstb), .Start_Stopb_In(start), .Up_Downb_In(up),
        .Clear_In(clr), .Load_In(ld), .Load_Value_In(ldv), .Count_Out(cnt_w[3]),
        .Max_Out(max_w[3]), .Min_Out(min_w[3]), .Wrap_Out(wrap_w[3]), .Sat_Out(sat_w[3]));

    typedef struct {
        bit start;
        bit up;
        bit clr;
        bit ld;
        int ldv;
        int cnt;
        bit wrap;
        bit mx;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCfg; k++) begin
            m_cnt[k] = 0;
            m_ps[k]  = 0;
            m_w[k]   = 0;
            m_s[k]   = 0;
        end
    endtask

    // One rising edge of the spec's behaviour, using the inputs currently applied.
    task automatic model_edge();
        for (int k = 0; k < NCfg; k++) begin
            int m;
            int nxt;
            m      = CfgMod[k];
            m_w[k] = 0;
            if (clr) begin
                m_cnt[k] = 0;
                m_ps[k]  = 0;
                m_s[k]   = 0;
            end else if (ld) begin
                m_cnt[k] = (int'(ldv) > m - 1) ? m - 1 : int'(ldv);
                m_ps[k]  = 0;
                m_s[k]   = 0;
            end else if (start) begin
                m_ps[k] = m_ps[k] + 1;
                if (m_ps[k] == CfgPs[k]) begin
                    m_ps[k] = 0;
                    nxt = m_cnt[k] + (up ? 1 : -1);
                    if (nxt >= 0 && nxt < m) begin
                        m_cnt[k] = nxt;
                        m_s[k]   = 0;
                    end else if (CfgSat[k] != 0) begin
                        m_s[k] = 1;
                    end else begin
                        m_cnt[k] = (nxt + m) % m;
                        m_w[k]   = 1;
                        m_s[k]   = 0;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rstb) model_edge();
        #1;
    endtask

    task automatic drive(input bit s, input bit u, input bit c, input bit l, input int v);
        start = s;
        up    = u;
        clr   = c;
        ld    = l;
        ldv   = 4'(v);
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < NCfg; k++) begin
            check($sformatf("%s c%0d count", tag, k), int'(cnt_w[k]), m_cnt[k]);
            check($sformatf("%s c%0d wrap", tag, k), int'(wrap_w[k]), int'(m_w[k]));
            check($sformatf("%s c%0d sat", tag, k), int'(sat_w[k]), int'(m_s[k]));
            check($sformatf("%s c%0d max", tag, k), int'(max_w[k]),
                  int'(m_cnt[k] == CfgMod[k] - 1));
            check($sformatf("%s c%0d min", tag, k), int'(min_w[k]), int'(m_cnt[k] == 0));
        end
    endtask

    initial begin
        vec_t tbl[$];
        int   sat_cnt [5];
        bit   sat_flag[5];
        int   ps_cnt  [14];
        bit   ps_en   [14];

        rstb = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NCfg; k++) begin
            check($sformatf("reset c%0d count", k), int'(cnt_w[k]), 0);
            check($sformatf("reset c%0d min", k), int'(min_w[k]), 1);
            check($sformatf("reset c%0d max", k), int'(max_w[k]), 0);
            check($sformatf("reset c%0d wrap", k), int'(wrap_w[k]), 0);
            check($sformatf("reset c%0d sat", k), int'(sat_w[k]), 0);
        end
        rstb = 1'b1;

        // Directed table for the default configuration.
        for (int i = 1; i <= 12; i++)
            tbl.push_back('{1, 1, 0, 0, 0, i % 10, (i == 10), (i == 9)});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 9, 1, 1});
        tbl.push_back('{1, 0, 0, 0, 0, 8, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 7, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 7, 7, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 8, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 12, 9, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 5, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 15, 9, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 9, 0, 1});
        foreach (tbl[i]) begin
            drive(tbl[i].start, tbl[i].up, tbl[i].clr, tbl[i].ld, tbl[i].ldv);
            cyc();
            check($sformatf("vec%0d count", i), int'(cnt_w[0]), tbl[i].cnt);
            check($sformatf("vec%0d wrap", i), int'(wrap_w[0]), int'(tbl[i].wrap));
            check($sformatf("vec%0d max", i), int'(max_w[0]), int'(tbl[i].mx));
        end

        // Saturating config: load 8, four up ticks, then reverse.
        sat_cnt  = '{9, 9, 9, 9, 8};
        sat_flag = '{0, 1, 1, 1, 0};
        drive(1, 1, 0, 1, 8);
        cyc();
        check("sat load count", int'(cnt_w[1]), 8);
        for (int i = 0; i < 5; i++) begin
            drive(1, (i < 4), 0, 0, 0);
            cyc();
            check($sformatf("sat%0d count", i), int'(cnt_w[1]), sat_cnt[i]);
            check($sformatf("sat%0d sat", i), int'(sat_w[1]), int'(sat_flag[i]));
            check($sformatf("sat%0d wrap", i), int'(wrap_w[1]), 0);
        end

        // Prescale-3 config: steps every third enabled edge; stop freezes the phase.
        ps_cnt = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3};
        ps_en  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        drive(1, 1, 1, 0, 0);
        cyc();
        for (int i = 0; i < 14; i++) begin
            drive(ps_en[i], 1, 0, 0, 0);
            cyc();
            check($sformatf("ps%0d count", i), int'(cnt_w[2]), ps_cnt[i]);
        end

        // Async reset between edges at count 5.
        drive(1, 1, 1, 0, 0);
        cyc();
        repeat (5) begin
            drive(1, 1, 0, 0, 0);
            cyc();
        end
        check("pre-reset count", int'(cnt_w[0]), 5);
        #2 rstb = 1'b0;
        #1;
        model_reset();
        check("async reset count", int'(cnt_w[0]), 0);
        check("async reset min", int'(min_w[0]), 1);
        @(posedge clk);
        #1 rstb = 1'b1;
        cyc();
        check("resume count", int'(cnt_w[0]), 1);

        // Async reset drops a sticky Sat_Out.
        drive(1, 1, 0, 1, 9);
        cyc();
        drive(1, 1, 0, 0, 0);
        cyc();
        check("sat before reset", int'(sat_w[1]), 1);
        #2 rstb = 1'b0;
        #1;
        model_reset();
        check("sat after async reset", int'(sat_w[1]), 0);
        check("sat cfg count after reset", int'(cnt_w[1]), 0);
        @(posedge clk);
        #1 rstb = 1'b1;

        // Random stimulus against the model on all configurations.
        compare_all("post");
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 77) begin
                #2 rstb = 1'b0;
                #1;
                model_reset();
                compare_all("rnd-reset");
                @(posedge clk);
                #1 rstb = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) up = ~up;
            drive(($urandom_range(0, 3) != 0), up, ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 15) == 0), int'($urandom_range(0, 15)));
            cyc();
            compare_all($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
